dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Sequencing controller for the data-memory subsystem of the single-cycle RISC-V core: direct-mapped, write-through, no-write-allocate data cache. It owns the tag/valid store, decides hit/miss for each load/store issued by the core, drives the cache data-array write port, runs line refills and write-through transfers over a req/ack main-memory port, and produces the `stall` that gates the PC enable.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width from the ALU result
- `DATA_W`, 32, data width
- `LINE_WORDS`, 4, words per line, power of two; `OFF_W = log2(LINE_WORDS)`
- `NUM_LINES`, 32, lines, power of two; `IDX_W = log2(NUM_LINES)`, `TAG_W = ADDR_W - IDX_W - OFF_W`

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `mem_read`  in  1  load request from control unit
- `mem_write`  in  1  store request from control unit
- `word_address`  in  ADDR_W  `{tag, index, offset}`
- `data_in`  in  DATA_W  store data
- `stall`  out  1  freeze PC and request; core must hold inputs stable while high
- `hit`  out  1  read-data mux select: cache array when 1
- `cache_we`  out  1  data-array write strobe
- `cache_waddr`  out  IDX_W+OFF_W  data-array word address `{index, offset}`
- `cache_wdata`  out  DATA_W  data-array write data
- `mm_req`, `mm_we`  out  1  main-memory request / write qualifier
- `mm_addr`  out  ADDR_W;  `mm_wdata`  out  DATA_W
- `mm_rdata`  in  DATA_W;  `mm_ack`  in  1  one-cycle completion pulse

## Operation
- `hit = valid[index] && tag_store[index] == tag`; combinational in IDLE and DONE, else 0.
- States: IDLE, REFILL, WRITE, DONE (enum in package).
- IDLE, `mem_write` (priority if both requests high): latch address/data; if hit, pulse `cache_we` with `cache_waddr = {index, offset}`, `cache_wdata = data_in`; go to WRITE.
- IDLE, `mem_read && !hit`: latch address, clear `cnt` (OFF_W bits); go to REFILL.
- IDLE, read hit or no request: stay; `stall = 0`.
- WRITE: `mm_req = 1`, `mm_we = 1`, `mm_addr`/`mm_wdata` from latch; on `mm_ack`, go to DONE.
- REFILL: `mm_req = 1`, `mm_we = 0`, `mm_addr = {tag, index, cnt}`. On `mm_ack`: `cache_we = 1`, `cache_waddr = {index, cnt}`, `cache_wdata = mm_rdata`, `cnt++`. On the ack with `cnt == LINE_WORDS-1`: write tag, set `valid[index]`, go to DONE.
- DONE: `stall = 0` for exactly one cycle; the held load now hits, and the held store is not reissued. Always return to IDLE.
- `stall = (IDLE && (mem_write || (mem_read && !hit))) || WRITE || REFILL`.
- `mm_*` outputs are driven only in WRITE/REFILL; `mm_req` is 0 elsewhere. `mm_addr` changes only in the cycle after an ack.

## Timing
- Reset (any state, including mid-refill): next state IDLE, all `valid` cleared, `cnt = 0`. While `reset` is high, `stall`, `hit`, `cache_we`, and `mm_req` are forced to 0. The partially refilled line stays invalid.
- Read hit: zero stall cycles.
- Read miss: stall = 1 (IDLE) + REFILL cycles through the final ack; then one DONE cycle.
- Store: stall = 1 (IDLE) + WRITE cycles through the ack; then one DONE cycle.
- `mm_ack` outside WRITE/REFILL is ignored.
- Back-to-back: a new request is evaluated in IDLE, the cycle after DONE.
- Address wrap: `cnt` wraps naturally; a refill never crosses the line.

## Structure
- `dcache_pkg`: state enum `dcache_state_t`, parameter-derived width functions (`OFF_W`, `IDX_W`, `TAG_W`), and field-slice helpers for `{tag, index, offset}`.
- Sub-module `dcache_tag_store`: tag array (not reset) and valid vector (synchronously cleared), one combinational read port, one write port. The data array stays outside this block.

## Test plan
- Memory model acks on the 3rd cycle of each held request. Load 0x024 after reset: `stall` high for 13 cycles, 4 `cache_we` pulses at `waddr` 0x24–0x27. In DONE, `hit = 1`.
- Same load repeated, then load 0x027: `stall` stays 0 and `hit = 1`. Load 0x0A4 (same index, new tag): 13-cycle refill, then 0x024 misses again.
- Store 0x025 = 0xDEADBEEF while the line is resident: one `cache_we` at 0x25 in the IDLE cycle, `mm_we = 1` and `mm_addr = 0x025`, `stall` high for 4 cycles, no further store issued.
- Store to a non-resident line: no `cache_we`, write-through only, `valid` unchanged.
- Assert `reset` during the 2nd refill word: next cycle IDLE, `mm_req = 0`. A re-issued load to the same address performs a full 4-word refill.
- `mem_read` and `mem_write` both high: write path taken, no refill started.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WRITE,
    ST_DONE
  } dcache_state_t;

  function automatic int unsigned calc_off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                             input int unsigned line_words,
                                             input int unsigned num_lines);
    return addr_w - $clog2(num_lines) - $clog2(line_words);
  endfunction

  // Generic field extract from a zero-extended word address; callers cast to the field width.
  function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_off(input logic [31:0] addr,
                                           input int unsigned off_w);
    return addr_field(addr, 0, off_w);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] addr,
                                           input int unsigned off_w,
                                           input int unsigned idx_w);
    return addr_field(addr, off_w, idx_w);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned off_w,
                                           input int unsigned idx_w,
                                           input int unsigned tag_w);
    return addr_field(addr, off_w + idx_w, tag_w);
  endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Tag array plus valid vector: one combinational read port, one synchronous write port.
module dcache_tag_store #(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned TAG_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid;

  // Valid bits clear on reset so a partially refilled line never reads as resident.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
    end
  end

  assign rd_tag   = tags[rd_idx];
  assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache sequencer with req/ack memory port.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 32,
  localparam int unsigned OFF_W     = calc_off_w(LINE_WORDS),
  localparam int unsigned IDX_W     = calc_idx_w(NUM_LINES),
  localparam int unsigned TAG_W     = calc_tag_w(ADDR_W, LINE_WORDS, NUM_LINES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [ADDR_W-1:0]      word_address,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   stall,
  output logic                   hit,
  output logic                   cache_we,
  output logic [IDX_W+OFF_W-1:0] cache_waddr,
  output logic [DATA_W-1:0]      cache_wdata,
  output logic                   mm_req,
  output logic                   mm_we,
  output logic [ADDR_W-1:0]      mm_addr,
  output logic [DATA_W-1:0]      mm_wdata,
  input  logic [DATA_W-1:0]      mm_rdata,
  input  logic                   mm_ack
);

  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

  dcache_state_t     state, state_n;
  logic [OFF_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_en, cnt_clr, cnt_inc, tag_we;

  logic [TAG_W-1:0]  tag_in, lat_tag, rd_tag;
  logic [IDX_W-1:0]  idx_in, lat_idx;
  logic [OFF_W-1:0]  off_in;
  logic              rd_valid, hit_raw;

  assign tag_in  = TAG_W'(addr_tag(32'(word_address), OFF_W, IDX_W, TAG_W));
  assign idx_in  = IDX_W'(addr_idx(32'(word_address), OFF_W, IDX_W));
  assign off_in  = OFF_W'(addr_off(32'(word_address), OFF_W));
  assign lat_tag = TAG_W'(addr_tag(32'(lat_addr), OFF_W, IDX_W, TAG_W));
  assign lat_idx = IDX_W'(addr_idx(32'(lat_addr), OFF_W, IDX_W));

  dcache_tag_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_tag_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx_in),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .wr_en    (tag_we),
    .wr_idx   (lat_idx),
    .wr_tag   (lat_tag)
  );

  // Lookup always uses the live address; the core holds it stable while stalled.
  assign hit_raw = rd_valid && (rd_tag == tag_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (lat_en) begin
      lat_addr <= word_address;
      lat_data <= data_in;
    end
  end

  always_comb begin
    state_n     = state;
    stall       = 1'b0;
    hit         = 1'b0;
    cache_we    = 1'b0;
    cache_waddr = '0;
    cache_wdata = '0;
    mm_req      = 1'b0;
    mm_we       = 1'b0;
    mm_addr     = '0;
    mm_wdata    = '0;
    lat_en      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    tag_we      = 1'b0;

    case (state)
      ST_IDLE: begin
        hit = hit_raw;
        if (mem_write) begin
          stall   = 1'b1;
          lat_en  = 1'b1;
          state_n = ST_WRITE;
          if (hit_raw) begin
            cache_we    = 1'b1;
            cache_waddr = {idx_in, off_in};
            cache_wdata = data_in;
          end
        end else if (mem_read && !hit_raw) begin
          stall   = 1'b1;
          lat_en  = 1'b1;
          cnt_clr = 1'b1;
          state_n = ST_REFILL;
        end
      end

      ST_REFILL: begin
        stall   = 1'b1;
        mm_req  = 1'b1;
        mm_addr = {lat_tag, lat_idx, cnt};
        if (mm_ack) begin
          cache_we    = 1'b1;
          cache_waddr = {lat_idx, cnt};
          cache_wdata = mm_rdata;
          cnt_inc     = 1'b1;
          if (cnt == CNT_LAST) begin
            tag_we  = 1'b1;
            state_n = ST_DONE;
          end
        end
      end

      ST_WRITE: begin
        stall    = 1'b1;
        mm_req   = 1'b1;
        mm_we    = 1'b1;
        mm_addr  = lat_addr;
        mm_wdata = lat_data;
        if (mm_ack) begin
          state_n = ST_DONE;
        end
      end

      ST_DONE: begin
        hit     = hit_raw;
        state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase

    // Reset masks every side effect in the cycle it is asserted.
    if (reset) begin
      stall    = 1'b0;
      hit      = 1'b0;
      cache_we = 1'b0;
      mm_req   = 1'b0;
      tag_we   = 1'b0;
      state_n  = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a memory model that acks on the 3rd cycle of each request.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [9:0]  word_address;
  logic [31:0] data_in;
  logic        stall, hit, cache_we;
  logic [6:0]  cache_waddr;
  logic [31:0] cache_wdata;
  logic        mm_req, mm_we;
  logic [9:0]  mm_addr;
  logic [31:0] mm_wdata, mm_rdata;
  logic        mm_ack;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .word_address (word_address),
    .data_in      (data_in),
    .stall        (stall),
    .hit          (hit),
    .cache_we     (cache_we),
    .cache_waddr  (cache_waddr),
    .cache_wdata  (cache_wdata),
    .mm_req       (mm_req),
    .mm_we        (mm_we),
    .mm_addr      (mm_addr),
    .mm_wdata     (mm_wdata),
    .mm_rdata     (mm_rdata),
    .mm_ack       (mm_ack)
  );

  always #5 clk = ~clk;

  // Memory returns a recognisable pattern so refill data can be checked per word.
  assign mm_rdata = 32'hC0DE_0000 | {22'd0, mm_addr};

  int wcnt;
  always @(posedge clk) begin
    if (reset || mm_ack) begin
      mm_ack <= 1'b0;
      wcnt   <= 0;
    end else if (mm_req) begin
      if (wcnt == 1) mm_ack <= 1'b1;
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  int          n_stall, n_we, n_rdreq, n_wrreq;
  logic [31:0] we_addr [8];
  logic [31:0] we_data [8];
  logic [31:0] last_mm_addr, last_mm_wdata;
  logic        done_hit;

  // Issue one request and hold it until stall drops; records what the controller did.
  task automatic do_op(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
    bit finished = 0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; word_address = a; data_in = d;
    n_stall = 0; n_we = 0; n_rdreq = 0; n_wrreq = 0; done_hit = 1'b0;
    last_mm_addr = '0; last_mm_wdata = '0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (cache_we) begin
        if (n_we < 8) begin
          we_addr[n_we] = 32'(cache_waddr);
          we_data[n_we] = cache_wdata;
        end
        n_we++;
      end
      if (mm_req) begin
        if (mm_we) n_wrreq++; else n_rdreq++;
        last_mm_addr  = 32'(mm_addr);
        last_mm_wdata = mm_wdata;
      end
      if (!stall) begin
        done_hit = hit;
        finished = 1;
        break;
      end
      n_stall++;
      @(negedge clk);
    end
    check_eq("op_completes", 32'(finished), 32'd1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    word_address = 10'h024; data_in = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_hit", 32'(hit), 32'd0);
    check_eq("rst_mm_req", 32'(mm_req), 32'd0);
    check_eq("rst_cache_we", 32'(cache_we), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_read = 1'b0;
    #1;
    check_eq("post_rst_hit", 32'(hit), 32'd0);
    check_eq("post_rst_stall", 32'(stall), 32'd0);

    // Cold miss on 0x024: 1 IDLE + 4 words x 3 cycles
    do_op(1'b1, 1'b0, 10'h024, '0);
    check_eq("miss_stall", 32'(n_stall), 32'd13);
    check_eq("miss_we_cnt", 32'(n_we), 32'd4);
    check_eq("miss_rdreq", 32'(n_rdreq), 32'd12);
    check_eq("miss_waddr0", we_addr[0], 32'h24);
    check_eq("miss_waddr3", we_addr[3], 32'h27);
    check_eq("miss_wdata0", we_data[0], 32'hC0DE_0024);
    check_eq("miss_wdata2", we_data[2], 32'hC0DE_0026);
    check_eq("done_hit", 32'(done_hit), 32'd1);

    do_op(1'b1, 1'b0, 10'h024, '0);
    check_eq("rehit_stall", 32'(n_stall), 32'd0);
    check_eq("rehit_hit", 32'(done_hit), 32'd1);
    do_op(1'b1, 1'b0, 10'h027, '0);
    check_eq("hit027_stall", 32'(n_stall), 32'd0);
    check_eq("hit027_hit", 32'(done_hit), 32'd1);

    // Conflict: 0x0A4 shares index 9 with 0x024
    do_op(1'b1, 1'b0, 10'h0A4, '0);
    check_eq("conf_stall", 32'(n_stall), 32'd13);
    check_eq("conf_waddr0", we_addr[0], 32'h24);
    check_eq("conf_wdata0", we_data[0], 32'hC0DE_00A4);
    check_eq("conf_wdata3", we_data[3], 32'hC0DE_00A7);
    do_op(1'b1, 1'b0, 10'h024, '0);
    check_eq("evicted_stall", 32'(n_stall), 32'd13);

    // Store hit: update array and write through
    do_op(1'b0, 1'b1, 10'h025, 32'hDEAD_BEEF);
    check_eq("st_hit_stall", 32'(n_stall), 32'd4);
    check_eq("st_hit_we_cnt", 32'(n_we), 32'd1);
    check_eq("st_hit_waddr", we_addr[0], 32'h25);
    check_eq("st_hit_wdata", we_data[0], 32'hDEAD_BEEF);
    check_eq("st_hit_wrreq", 32'(n_wrreq), 32'd3);
    check_eq("st_hit_rdreq", 32'(n_rdreq), 32'd0);
    check_eq("st_hit_mm_addr", last_mm_addr, 32'h025);
    check_eq("st_hit_mm_wdata", last_mm_wdata, 32'hDEAD_BEEF);
    idle_cycle();
    check_eq("st_no_reissue", 32'(mm_req), 32'd0);
    do_op(1'b1, 1'b0, 10'h025, '0);
    check_eq("st_line_kept", 32'(n_stall), 32'd0);

    // Store miss: write-through only, no allocation
    do_op(1'b0, 1'b1, 10'h300, 32'h1234_5678);
    check_eq("st_miss_stall", 32'(n_stall), 32'd4);
    check_eq("st_miss_we_cnt", 32'(n_we), 32'd0);
    check_eq("st_miss_mm_addr", last_mm_addr, 32'h300);
    do_op(1'b1, 1'b0, 10'h300, '0);
    check_eq("st_miss_no_alloc", 32'(n_stall), 32'd13);

    // Reset during the second refill word of 0x1C8
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; word_address = 10'h1C8;
    repeat (4) @(negedge clk);
    #1;
    check_eq("rf_word1_req", 32'(mm_req), 32'd1);
    check_eq("rf_word1_addr", 32'(mm_addr), 32'h1C9);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rf_rst_stall", 32'(stall), 32'd0);
    check_eq("rf_rst_mm_req", 32'(mm_req), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_read = 1'b0;
    #1;
    check_eq("rf_after_rst_req", 32'(mm_req), 32'd0);
    check_eq("rf_after_rst_stall", 32'(stall), 32'd0);
    do_op(1'b1, 1'b0, 10'h1C8, '0);
    check_eq("rf_redo_stall", 32'(n_stall), 32'd13);
    check_eq("rf_redo_we_cnt", 32'(n_we), 32'd4);
    check_eq("rf_redo_waddr0", we_addr[0], 32'h48);
    check_eq("rf_redo_wdata0", we_data[0], 32'hC0DE_01C8);

    // Both requests high: store path wins, no refill
    do_op(1'b1, 1'b1, 10'h024, 32'hCAFE_F00D);
    check_eq("both_stall", 32'(n_stall), 32'd4);
    check_eq("both_rdreq", 32'(n_rdreq), 32'd0);
    check_eq("both_wrreq", 32'(n_wrreq), 32'd3);
    check_eq("both_we_cnt", 32'(n_we), 32'd0);
    check_eq("both_mm_wdata", last_mm_wdata, 32'hCAFE_F00D);
    do_op(1'b1, 1'b0, 10'h024, '0);
    check_eq("both_then_miss", 32'(n_stall), 32'd13);

    idle_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
